mult_div_unit: RTL and testbench

//   Iterative multiply/divide unit in EX, fed by the register-file read ports (rs, rt).

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/mdu_iter_core.sv | 74 +++++++
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state names and the quotient returned for a zero divisor.
package cpu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE  = 2'b00,
        MDU_CALC  = 2'b01,
        MDU_FIXUP = 2'b10
    } mdu_state_e;

    // Widest operand this unit is expected to be built with.
    localparam int MDU_MAX_WIDTH = 64;

    // LO value for a zero divisor (all ones, sliced down to the operand width).
    localparam logic [MDU_MAX_WIDTH-1:0] DIV0_LO = '1;

endpackage

// File: rtl/mdu_iter_core.sv
// One-step-per-cycle datapath shared by multiply and divide.
// Multiply: shift-add, with the multiplier held in r_lo and consumed LSB first.
//   The product high half accumulates in r_acc, and its low half shifts into r_lo.
// Divide: restoring division. r_acc holds the partial remainder, and r_lo starts
//   as the dividend and fills with quotient bits from the bottom.
module mdu_iter_core
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_isDiv,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_isDiv;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // Combinational step: a (WIDTH+1)-bit add for multiply, and a shift-and-trial-subtract for divide.
    always_comb begin
        w_addend = r_lo[0] ? r_b : '0;
        w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
        w_shift  = {r_acc, r_lo[WIDTH-1]};
        w_diff   = w_shift - {1'b0, r_b};
        w_fits   = ~w_diff[WIDTH];
    end

    // Accumulator registers: loaded at launch, then advanced one radix-2 step per cycle.
    // The remainder is always below the divisor, so it fits back into WIDTH bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_lo    <= '0;
            r_b     <= '0;
            r_isDiv <= 1'b0;
        end else if (i_load) begin
            r_acc   <= '0;
            r_isDiv <= i_isDiv;
            r_lo    <= i_isDiv ? i_a : i_b;
            r_b     <= i_isDiv ? i_b : i_a;
        end else if (i_step) begin
            if (r_isDiv) begin
                if (w_fits) begin
                    r_acc <= w_diff[WIDTH-1:0];
                    r_lo  <= {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_acc <= w_shift[WIDTH-1:0];
                    r_lo  <= {r_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                r_acc <= w_sum[WIDTH:1];
                r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
            end
        end
    end

    assign o_hi = r_acc;
    assign o_lo = r_lo;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
// The core works on operand magnitudes. Signs are recorded at launch and applied
// in a single fixup cycle before HI/LO are written. The unit reports busy for the
// whole operation so that dependent HI/LO traffic can be stalled upstream.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    mdu_state_e       r_state;
    mdu_state_e       w_nextState;
    logic [CW-1:0]    r_count;
    logic             r_isDiv;
    logic             r_negRes;
    logic             r_negRem;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_launch;
    logic             w_signed;
    logic             w_aNeg;
    logic             w_bNeg;
    logic [WIDTH-1:0] w_aMag;
    logic [WIDTH-1:0] w_bMag;
    logic [WIDTH-1:0] w_coreHi;
    logic [WIDTH-1:0] w_coreLo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0] w_quotFix;
    logic [WIDTH-1:0] w_remFix;
    logic [WIDTH-1:0] w_newHi;
    logic [WIDTH-1:0] w_newLo;

    // Launch decode, and operand magnitudes for the signed variants.
    always_comb begin
        w_launch = (r_state == MDU_IDLE) && start;
        w_signed = (mdu_op_e'(op) == MDU_MULT) || (mdu_op_e'(op) == MDU_DIV);
        w_aNeg   = w_signed && opa[WIDTH-1];
        w_bNeg   = w_signed && opb[WIDTH-1];
        w_aMag   = w_aNeg ? (~opa + 1'b1) : opa;
        w_bMag   = w_bNeg ? (~opb + 1'b1) : opb;
    end

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_launch),
        .i_step  (r_state == MDU_CALC),
        .i_isDiv (op[1]),
        .i_a     (w_aMag),
        .i_b     (w_bMag),
        .o_hi    (w_coreHi),
        .o_lo    (w_coreLo)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: IDLE -> CALC on start, CALC for WIDTH steps, then one FIXUP cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            MDU_IDLE:  if (start) w_nextState = MDU_CALC;
            MDU_CALC:  if (r_count == CW'(WIDTH - 1)) w_nextState = MDU_FIXUP;
            MDU_FIXUP: w_nextState = MDU_IDLE;
            default:   w_nextState = MDU_IDLE;
        endcase
    end

    // Step counter: cleared at launch, advanced once per CALC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_launch) begin
            r_count <= '0;
        end else if (r_state == MDU_CALC) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Operation kind and result signs, captured at launch for use in the fixup cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_isDiv  <= 1'b0;
            r_negRes <= 1'b0;
            r_negRem <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_launch) begin
            r_isDiv  <= op[1];
            r_negRes <= w_aNeg ^ w_bNeg;
            r_negRem <= w_aNeg;
            r_div0   <= op[1] && (opb == '0);
        end
    end

    // Sign fixup. For a zero divisor, the magnitude path already leaves the dividend in
    // the remainder, so only the quotient has to be forced.
    always_comb begin
        w_prod    = {w_coreHi, w_coreLo};
        w_prodFix = r_negRes ? (~w_prod + 1'b1) : w_prod;
        w_quotFix = r_negRes ? (~w_coreLo + 1'b1) : w_coreLo;
        w_remFix  = r_negRem ? (~w_coreHi + 1'b1) : w_coreHi;
        if (r_div0) begin
            w_quotFix = DIV0_LO[WIDTH-1:0];
        end
        w_newHi = r_isDiv ? w_remFix  : w_prodFix[2*WIDTH-1:WIDTH];
        w_newLo = r_isDiv ? w_quotFix : w_prodFix[WIDTH-1:0];
    end

    // HI/LO: the op result is written in FIXUP. MTHI/MTLO writes are taken only in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == MDU_FIXUP) begin
            r_hi <= w_newHi;
            r_lo <= w_newLo;
        end else if (r_state == MDU_IDLE) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
        end
    end

    // Completion pulse, high in the cycle after HI/LO are written.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == MDU_FIXUP);
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != MDU_IDLE);
    assign done = r_done;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit, with hand-computed HI/LO results,
// latency, busy/done behaviour, MTHI/MTLO interaction and mid-operation reset.
module tb_mult_div_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .opa   (opa),
        .opb   (opb),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and count and report it if it misses.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Launch an op across one rising edge (E0). Returns 1 ns after that edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        opa   = a;
        opb   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen, bounded to 100 cycles.
    task automatic waitDone(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Run an op to completion and check result, latency and the shape of the done pulse.
    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        int lat;
        applyStimulus(o, a, b);
        checkOutput({tag, " busy after launch"}, {31'd0, busy}, 32'd1);
        waitDone(lat);
        checkOutput({tag, " latency"}, lat, 32'd33);
        checkOutput({tag, " hi"}, hi, expHi);
        checkOutput({tag, " lo"}, lo, expLo);
        checkOutput({tag, " busy at done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, " done one cycle"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        logic sawDone;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        opa   = '0;
        opb   = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hi", hi, 32'h0);
        checkOutput("reset lo", lo, 32'h0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] multiply cases");
        runOp("MULTU max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        runOp("MULT -7*3", MDU_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        runOp("MULT min*min", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        runOp("MULTU 6*7", MDU_MULTU, 32'd6, 32'd7, 32'h0, 32'd42);

        $display("[TB] divide cases");
        runOp("DIV -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("DIVU 100/7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        runOp("DIV min/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        runOp("DIV 7/-2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        runOp("DIV -5/0", MDU_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        $display("[TB] divide by zero with start while busy");
        applyStimulus(MDU_DIVU, 32'd5, 32'd0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        op    = MDU_MULTU;
        opa   = 32'd3;
        opb   = 32'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(lat);
        checkOutput("DIVU 5/0 latency", lat + 10, 32'd33);
        checkOutput("DIVU 5/0 hi", hi, 32'd5);
        checkOutput("DIVU 5/0 lo", lo, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        checkOutput("ignored start stays idle", {31'd0, busy}, 32'd0);

        $display("[TB] MTHI/MTLO");
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h0000_5678;
        checkOutput("MTHI hi", hi, 32'h0000_1234);
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        checkOutput("MTLO lo", lo, 32'h0000_5678);
        checkOutput("MTLO hi kept", hi, 32'h0000_1234);

        // MTHI in the same cycle as start applies, and the result then overwrites it.
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hAAAA_5555;
        applyStimulus(MDU_DIVU, 32'd100, 32'd7);
        hi_we = 1'b0;
        lo_we = 1'b0;
        checkOutput("MT with start hi", hi, 32'hAAAA_5555);
        checkOutput("MT with start lo", lo, 32'hAAAA_5555);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        checkOutput("MTHI while busy ignored", hi, 32'hAAAA_5555);
        waitDone(lat);
        checkOutput("MT overwrite latency", lat + 6, 32'd33);
        checkOutput("MT overwrite hi", hi, 32'd2);
        checkOutput("MT overwrite lo", lo, 32'd14);

        $display("[TB] reset mid-operation");
        applyStimulus(MDU_MULTU, 32'd9, 32'd9);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort hi", hi, 32'h0);
        checkOutput("abort lo", lo, 32'h0);
        sawDone = 1'b0;
        repeat (40) begin
            if (done === 1'b1) sawDone = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("abort no done", {31'd0, sawDone}, 32'd0);
        runOp("after abort MULTU", MDU_MULTU, 32'h0001_0000, 32'h0003_0000, 32'h0000_0003, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
